// File: rtl/fir_tcdm_responder_if.sv
// TCDM request/response bundle shared by the streamer initiator ports and the banked responder.
// Per-port fields are packed side by side, port p in slice [p*W +: W].
interface fir_tcdm_responder_if #(
    parameter int unsigned MP         = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [MP-1:0]            req;
    logic [MP-1:0]            gnt;
    logic [MP*ADDR_WIDTH-1:0] add;
    logic [MP-1:0]            wen;
    logic [MP*BE_WIDTH-1:0]   be;
    logic [MP*DATA_WIDTH-1:0] data;
    logic [MP*DATA_WIDTH-1:0] r_data;
    logic [MP-1:0]            r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/fir_tcdm_responder.sv
// Word-interleaved banked TCDM responder: per-bank round-robin arbitration with combinational
// grant and a fixed one-cycle registered response for reads and writes.
module fir_tcdm_responder #(
    parameter int unsigned MP         = 3,
    parameter int unsigned NB_BANKS   = 4,
    parameter int unsigned BANK_DEPTH = 256,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic [NB_BANKS-1:0]       stall_mask_i,
    fir_tcdm_responder_if.slave       tcdm
);
    localparam int unsigned BANK_BITS = $clog2(NB_BANKS);
    localparam int unsigned ROW_BITS  = $clog2(BANK_DEPTH);
    localparam int unsigned ROW_LSB   = 2 + BANK_BITS;
    localparam int unsigned PTR_W     = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned BE_W      = DATA_WIDTH / 8;

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t                     rr_q [NB_BANKS];
    ptr_t                     rr_d [NB_BANKS];
    logic [MP-1:0]            r_valid_q, r_valid_d;
    logic [MP*DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [MP-1:0]            gnt_c;

    logic [BANK_BITS-1:0]     port_bank [MP];
    logic [ROW_BITS-1:0]      port_row  [MP];

    logic [NB_BANKS-1:0]      wr_en;
    logic [ROW_BITS-1:0]      wr_row  [NB_BANKS];
    logic [DATA_WIDTH-1:0]    wr_data [NB_BANKS];
    logic [BE_W-1:0]          wr_be   [NB_BANKS];

    logic [DATA_WIDTH-1:0]    mem_q [NB_BANKS][BANK_DEPTH];

    // Address decode: byte offset dropped, bank from the low word bits, row above it.
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            port_bank[p] = tcdm.add[p*ADDR_WIDTH+2 +: BANK_BITS];
            port_row[p]  = tcdm.add[p*ADDR_WIDTH+ROW_LSB +: ROW_BITS];
        end
    end

    // Per-bank round-robin pick, grant, response and write-port generation.
    always_comb begin
        logic found;
        ptr_t pick;
        int   cand;

        gnt_c     = '0;
        r_valid_d = '0;
        r_data_d  = '0;
        wr_en     = '0;
        found     = 1'b0;
        pick      = '0;
        cand      = 0;
        for (int b = 0; b < NB_BANKS; b++) begin
            rr_d[b]    = clear_i ? '0 : rr_q[b];
            wr_row[b]  = '0;
            wr_data[b] = '0;
            wr_be[b]   = '0;
        end

        for (int b = 0; b < NB_BANKS; b++) begin
            found = 1'b0;
            pick  = '0;
            for (int o = 0; o < MP; o++) begin
                cand = (int'(rr_q[b]) + o) % int'(MP);
                if (!found && tcdm.req[cand] && (port_bank[cand] == BANK_BITS'(b))) begin
                    found = 1'b1;
                    pick  = PTR_W'(cand);
                end
            end

            // Clear and stall both veto the grant, so nothing below happens for this bank.
            if (found && !stall_mask_i[b] && !clear_i) begin
                gnt_c[pick]     = 1'b1;
                r_valid_d[pick] = 1'b1;
                rr_d[b]         = (pick == PTR_W'(MP-1)) ? '0 : pick + PTR_W'(1);
                if (tcdm.wen[pick]) begin
                    r_data_d[int'(pick)*DATA_WIDTH +: DATA_WIDTH] = mem_q[b][port_row[pick]];
                end else begin
                    wr_en[b]   = 1'b1;
                    wr_row[b]  = port_row[pick];
                    wr_data[b] = tcdm.data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    wr_be[b]   = tcdm.be[int'(pick)*BE_W +: BE_W];
                end
            end
        end
    end

    // Memory content is deliberately left out of reset; a reset edge only blocks the write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q      <= '{default: '0};
            r_valid_q <= '0;
            r_data_q  <= '0;
        end else begin
            rr_q      <= rr_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            for (int b = 0; b < NB_BANKS; b++) begin
                if (wr_en[b]) begin
                    for (int k = 0; k < BE_W; k++) begin
                        if (wr_be[b][k]) begin
                            mem_q[b][wr_row[b]][8*k +: 8] <= wr_data[b][8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    assign tcdm.gnt     = gnt_c;
    assign tcdm.r_valid = r_valid_q;
    assign tcdm.r_data  = r_data_q;

endmodule

// File: tb/tb_fir_tcdm_responder.sv
// Directed bench for fir_tcdm_responder: flat word-memory reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_fir_tcdm_responder;
    localparam int unsigned MP    = 3;
    localparam int unsigned NB    = 4;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned BEW   = DW / 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          clear = 1'b0;
    logic [NB-1:0] stall = '0;

    fir_tcdm_responder_if #(.MP(MP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) tcdm ();

    fir_tcdm_responder #(
        .MP(MP), .NB_BANKS(NB), .BANK_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .stall_mask_i (stall),
        .tcdm         (tcdm)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: flat word array, per-bank pointers and expected next-cycle response.
    logic [DW-1:0] m_mem   [NB*DEPTH];
    bit            m_known [NB*DEPTH];
    int            m_ptr   [NB];
    logic [MP-1:0] e_rv = '0;
    logic [DW-1:0] e_rd    [MP];
    bit            e_known [MP];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [AW-1:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [AW-1:0] addr_of(input int p);
        return tcdm.add[p*AW +: AW];
    endfunction

    function automatic logic [MP-1:0] model_gnt();
        logic [MP-1:0] g;
        int p;
        g = '0;
        if (clear) return g;
        for (int b = 0; b < NB; b++) begin
            if (!stall[b]) begin
                for (int o = 0; o < MP; o++) begin
                    p = (m_ptr[b] + o) % MP;
                    if (tcdm.req[p] && (word_of(addr_of(p)) % NB == b)) begin
                        g[p] = 1'b1;
                        break;
                    end
                end
            end
        end
        return g;
    endfunction

    initial begin : model
        logic [MP-1:0] g;
        int w;
        for (int p = 0; p < MP; p++) begin
            e_rd[p]    = '0;
            e_known[p] = 1'b1;
        end
        for (int b = 0; b < NB; b++) m_ptr[b] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int b = 0; b < NB; b++) m_ptr[b] = 0;
                e_rv = '0;
                for (int p = 0; p < MP; p++) begin
                    e_rd[p]    = '0;
                    e_known[p] = 1'b1;
                end
            end else begin
                g    = model_gnt();
                e_rv = g;
                for (int p = 0; p < MP; p++) begin
                    e_rd[p]    = '0;
                    e_known[p] = 1'b1;
                    if (g[p] && tcdm.wen[p]) begin
                        w          = word_of(addr_of(p));
                        e_rd[p]    = m_mem[w];
                        e_known[p] = m_known[w];
                    end
                end
                for (int p = 0; p < MP; p++) begin
                    if (g[p]) begin
                        w = word_of(addr_of(p));
                        m_ptr[w % NB] = (p + 1) % MP;
                        if (!tcdm.wen[p]) begin
                            for (int k = 0; k < BEW; k++)
                                if (tcdm.be[p*BEW+k]) m_mem[w][8*k +: 8] = tcdm.data[p*DW+8*k +: 8];
                            if (tcdm.be[p*BEW +: BEW] == '1) m_known[w] = 1'b1;
                        end
                    end
                end
                if (clear) for (int b = 0; b < NB; b++) m_ptr[b] = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin : compare
        logic [MP-1:0] eg;
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                eg = model_gnt();
                chk("gnt", DW'(tcdm.gnt), DW'(eg));
                chk("r_valid", DW'(tcdm.r_valid), DW'(e_rv));
                for (int p = 0; p < MP; p++)
                    if (e_rv[p] && e_known[p])
                        chk($sformatf("r_data%0d", p), tcdm.r_data[p*DW +: DW], e_rd[p]);
            end
        end
    end

    task automatic drive(input int p, input bit rq, input logic [AW-1:0] a, input bit w,
                         input logic [BEW-1:0] b, input logic [DW-1:0] d);
        tcdm.req[p]             = rq;
        tcdm.add[p*AW +: AW]    = a;
        tcdm.wen[p]             = w;
        tcdm.be[p*BEW +: BEW]   = b;
        tcdm.data[p*DW +: DW]   = d;
    endtask

    task automatic idle();
        tcdm.req  = '0;
        tcdm.add  = '0;
        tcdm.wen  = '0;
        tcdm.be   = '0;
        tcdm.data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return tcdm.r_data[p*DW +: DW];
    endfunction

    logic [AW-1:0] t3_addr [3] = '{32'h04, 32'h14, 32'h24};
    logic [DW-1:0] t3_data [3] = '{32'hB100_0004, 32'hB200_0014, 32'hB300_0024};
    logic [MP-1:0] rot     [3] = '{3'b001, 3'b010, 3'b100};

    initial begin : main
        idle();
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r_valid", DW'(tcdm.r_valid), 32'h0);
        for (int p = 0; p < MP; p++) chk($sformatf("rst_r_data%0d", p), rd(p), 32'h0);
        chk("rst_gnt", DW'(tcdm.gnt), 32'h0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // Write then read one word.
        drive(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'hDEAD_BEEF);
        #1 chk("t1_wr_gnt", DW'(tcdm.gnt), 32'h1);
        tick();
        drive(0, 1'b1, 32'h10, 1'b1, 4'hF, 32'h0);
        #1 chk("t1_wr_rvalid", DW'(tcdm.r_valid), 32'h1);
        chk("t1_wr_rdata", rd(0), 32'h0);
        chk("t1_rd_gnt", DW'(tcdm.gnt), 32'h1);
        tick();
        idle();
        #1 chk("t1_rd_rvalid", DW'(tcdm.r_valid), 32'h1);
        chk("t1_rd_data", rd(0), 32'hDEAD_BEEF);
        tick();

        // Byte-enable merge.
        drive(0, 1'b1, 32'h20, 1'b0, 4'b1111, 32'h1122_3344);
        tick();
        drive(0, 1'b1, 32'h20, 1'b0, 4'b0101, 32'hAABB_CCDD);
        tick();
        drive(0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0);
        tick();
        idle();
        #1 chk("t2_merge", rd(0), 32'h11BB_33DD);
        tick();

        // Preload bank 1 via port 2 so its pointer ends at 0, then three-way contention.
        for (int i = 0; i < 3; i++) begin
            drive(2, 1'b1, t3_addr[i], 1'b0, 4'hF, t3_data[i]);
            tick();
        end
        idle();
        for (int p = 0; p < MP; p++) drive(p, 1'b1, t3_addr[p], 1'b1, 4'h0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("t3_gnt%0d", c), DW'(tcdm.gnt), DW'(rot[c % 3]));
            if (c > 0) begin
                chk($sformatf("t3_rvalid%0d", c), DW'(tcdm.r_valid), DW'(rot[(c-1) % 3]));
                chk($sformatf("t3_rdata%0d", c), rd((c-1) % 3), t3_data[(c-1) % 3]);
            end
            tick();
        end
        idle();
        tick();

        // Parallel grants on distinct banks.
        drive(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'hA000_0040);
        drive(1, 1'b1, 32'h44, 1'b0, 4'hF, 32'hA100_0044);
        drive(2, 1'b1, 32'h48, 1'b0, 4'hF, 32'hA200_0048);
        #1 chk("t4_wr_gnt", DW'(tcdm.gnt), 32'h7);
        tick();
        for (int p = 0; p < MP; p++) tcdm.wen[p] = 1'b1;
        #1 chk("t4_rd_gnt", DW'(tcdm.gnt), 32'h7);
        chk("t4_wr_rvalid", DW'(tcdm.r_valid), 32'h7);
        tick();
        idle();
        #1 chk("t4_rd_rvalid", DW'(tcdm.r_valid), 32'h7);
        chk("t4_rd0", rd(0), 32'hA000_0040);
        chk("t4_rd1", rd(1), 32'hA100_0044);
        chk("t4_rd2", rd(2), 32'hA200_0048);
        tick();

        // Bank 1 stalled for five cycles; bank 0 keeps flowing.
        stall = 4'b0010;
        drive(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h14, 1'b1, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("t5_stall%0d", i), DW'(tcdm.gnt), 32'h1);
            tick();
        end
        stall = '0;
        #1 chk("t5_release", DW'(tcdm.gnt), 32'h3);
        tick();
        idle();
        tick();

        // Async reset right after a read grant; a write presented across reset must not land.
        drive(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        tick();
        drive(0, 1'b1, 32'h44, 1'b0, 4'hF, 32'h5555_5555);
        rst = 1'b1;
        #1 chk("t6_rvalid_async", DW'(tcdm.r_valid), 32'h0);
        tick();
        idle();
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 32'h44, 1'b1, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h14, 1'b1, 4'h0, 32'h0);
        drive(2, 1'b1, 32'h24, 1'b1, 4'h0, 32'h0);
        #1 chk("t6_ptr_reset", DW'(tcdm.gnt), 32'h1);
        tick();
        idle();
        drive(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        #1 chk("t6_no_write_in_rst", rd(0), 32'hA100_0044);
        tick();
        idle();
        #1 chk("t6_retained", rd(0), 32'hA000_0040);
        tick();

        // Clear kills grants and the following response.
        drive(0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h14, 1'b1, 4'h0, 32'h0);
        clear = 1'b1;
        #1 chk("t7_clear_gnt", DW'(tcdm.gnt), 32'h0);
        tick();
        clear = 1'b0;
        idle();
        #1 chk("t7_clear_rvalid", DW'(tcdm.r_valid), 32'h0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_tcdm_responder.md
Name: fir_tcdm_responder

Overview:
- Multi-port, word-interleaved, banked TCDM memory responder. It serves the HCI core initiator ports of the FIR accelerator's streamer (MP ports).
- Sits in the FIR HWPE testbench and subsystem wrapper as the memory end of the TCDM protocol.
- Arbitrates per bank with round-robin, grants combinationally and returns read data with a fixed 1-cycle latency.

Parameters:
- MP, 3: number of initiator ports served.
- NB_BANKS, 4: number of word-interleaved banks (power of 2, ≥2).
- BANK_DEPTH, 256: words per bank (power of 2).
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear of arbiter pointers and pending responses.
- stall_mask_i  in  NB_BANKS  bank b may not grant while bit b=1 (bench backpressure).
- req_i  in  MP  per-port request.
- gnt_o  out  MP  per-port grant, combinational from req_i/add_i/stall_mask_i/pointers.
- add_i  in  MP*ADDR_WIDTH  per-port byte address.
- wen_i  in  MP  1=read, 0=write.
- be_i  in  MP*DATA_WIDTH/8  per-port byte enables (writes only).
- data_i  in  MP*DATA_WIDTH  per-port write data.
- r_data_o  out  MP*DATA_WIDTH  per-port read data.
- r_valid_o  out  MP  per-port response valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk_i, rst_i).
- Address decode:
  - add[1:0] ignored.
  - bank = add[2 +: log2(NB_BANKS)].
  - row = next log2(BANK_DEPTH) bits.
  - Upper bits ignored; aliasing wraps silently.
- Arbitration, independently per bank:
  - Candidates are ports with req_i=1 whose bank matches.
  - Winner is the first candidate at or after rr_ptr[b], searching upward mod MP.
  - gnt_o[winner]=1 in the same cycle, unless stall_mask_i[b]=1; then no port targeting b is granted.
  - At most one grant per bank per cycle. Ports targeting different banks are granted in parallel.
- Pointer update: on a grant at bank b, rr_ptr[b] <= (winner+1) mod MP at the clock edge. Otherwise unchanged.
- Request persistence: an ungranted initiator holds req/add/wen/be/data. The responder does not depend on this for correctness.
- Write, on a granted cycle with wen=0: bank[row] byte k updated iff be[k]=1, at the clock edge.
- Read, on a granted cycle with wen=1: r_data_o[p] is registered at the edge and shows the bank word in cycle N+1.
- Response timing:
  - r_valid_o[p]=1 for exactly one cycle, one cycle after every grant, for both reads and writes.
  - For writes, r_data_o[p]=0.
  - r_valid_o is 0 in all other cycles.
- Back-to-back grants to the same port give back-to-back r_valid pulses (throughput 1 per cycle per port).
- Ordering and hazards:
  - A write granted in cycle N followed by a read of the same word granted in N+1 returns the new data.
  - A same-cycle write and read to one word cannot both be granted, because both map to the same bank.
- Reset values:
  - gnt_o follows combinational logic; with pointers at 0 it is 0 when req_i=0.
  - r_valid_o=0, r_data_o=0, all rr_ptr=0.
  - Memory contents are NOT reset.
- Reset mid-operation: responses pending from the previous cycle are dropped (r_valid_o forced 0). Write on the reset edge: no memory update.
- clear_i: same effect as reset on pointers/r_valid_o/r_data_o. Grants in a clear cycle do not update memory or produce responses, and gnt_o is forced 0 while clear_i=1.
- Simultaneous events: rst_i dominates clear_i, which dominates stall_mask_i, which dominates arbitration.
- Implementation: memory is a behavioural register array (NB_BANKS×BANK_DEPTH×DATA_WIDTH). No SRAM macros.

Test Plan:
1. Port0 writes 0xDEADBEEF to addr 0x10 (bank 0, row 1), then reads it → gnt same cycle, r_valid one cycle later, read returns 0xDEADBEEF, write r_data=0.
2. Byte enables: write 0x11223344 be=4'b1111, then 0xAABBCCDD be=4'b0101 to 0x20 → read gives 0x11BB33DD.
3. All 3 ports read bank 1 (0x04, 0x14, 0x24) continuously → grants rotate 0,1,2,0,1,2. Each port gets one r_valid per 3 cycles, data matches preloaded words.
4. Ports 0/1/2 target banks 0/1/2 at the same time → all three granted every cycle; 3 r_valid pulses per cycle after a 1-cycle latency.
5. stall_mask_i=4'b0010 for 5 cycles while port1 requests bank 1 → gnt_o[1]=0 for 5 cycles, then granted on cycle 6. Port0 on bank 0 is unaffected.
6. Assert rst_i asynchronously the cycle after a read grant → r_valid_o drops immediately, rr_ptr=0. A memory word written earlier still reads back its value after reset release.
